// File: rtl/boot_pkg.sv
// Shared types and constants for the boot/programming-mode controller.
// Optional single-step mode is compiled in with BOOT_CTRL_STEP_EN.
package boot_pkg;

    localparam int ADR_W_DEF       = 15;
    localparam int NUM_BANKS_DEF   = 2;
    localparam int DEBOUNCE_DEF    = 20000;
    localparam int RST_HOLD_DEF    = 16;
    localparam int DIV_MAX_DEF     = 24;

    // Bank indices selected by the top programmer address bits
    localparam int BANK_ROM        = 0;
    localparam int BANK_DMEM       = 1;

    // div_sel value that requests single-step operation
    localparam logic [4:0] STEP_SEL = 5'd31;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_PROG = 2'd2
`ifdef BOOT_CTRL_STEP_EN
        ,
        ST_STEP = 2'd3
`endif
    } state_e;

    // Limit the divider select to the largest legal exponent
    function automatic logic [4:0] clamp_sel(input logic [4:0] sel, input int max_sel);
        logic [4:0] res;
        if (sel > 5'(max_sel)) begin
            res = 5'(max_sel);
        end else begin
            res = sel;
        end
        return res;
    endfunction

endpackage

// File: rtl/boot_ctrl_if.sv
// Programmer-side bus: write strobe, word address, transfer-done level and
// the resulting per-bank write enables.
interface boot_ctrl_if
    import boot_pkg::*;
#(
    parameter int ADR_W     = ADR_W_DEF,
    parameter int NUM_BANKS = NUM_BANKS_DEF
) ();

    logic                 upg_wen_i;
    logic [ADR_W-1:0]     upg_adr_i;
    logic                 upg_done_i;
    logic [NUM_BANKS-1:0] bank_wen;

    modport master (
        output upg_wen_i,
        output upg_adr_i,
        output upg_done_i,
        input  bank_wen
    );

    modport slave (
        input  upg_wen_i,
        input  upg_adr_i,
        input  upg_done_i,
        output bank_wen
    );

endinterface

// File: rtl/boot_ctrl_debounce_sync.sv
// Button conditioner: 2-flop synchroniser, stability counter and a
// single-shot accept pulse that re-arms only after the input returns low.
module debounce_sync #(
    parameter int CYCLES = 20000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic din_i,
    output logic accept_o
);

    localparam int CNT_W = $clog2(CYCLES + 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Two-flop synchroniser for the asynchronous pin
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= din_i;
            sync2_q <= sync1_q;
        end
    end

    // Stability count: clears while low, saturates at CYCLES while high
    always_comb begin
        cnt_d = cnt_q;
        if (!sync2_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(CYCLES)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Stability counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the one cycle where the count steps onto CYCLES
    assign accept_o = sync2_q && (cnt_q == CNT_W'(CYCLES - 1));

endmodule

// File: rtl/boot_ctrl.sv
// Boot / programming-mode controller: reset sequencing, CPU clock-enable
// divider and programmer write steering to memory banks.
// Optional single-step mode is compiled in with BOOT_CTRL_STEP_EN.
module boot_ctrl
    import boot_pkg::*;
#(
    parameter int ADR_W           = ADR_W_DEF,
    parameter int NUM_BANKS       = NUM_BANKS_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int RST_HOLD_CYCLES = RST_HOLD_DEF,
    parameter int DIV_MAX         = DIV_MAX_DEF
) (
    input  logic        fpga_clk,
    input  logic        fpga_rst_n,
    input  logic        start_pg,
    input  logic [4:0]  div_sel,
    boot_ctrl_if.slave  upg,
    output logic        upg_rst,
    output logic        cpu_rst,
    output logic        cpu_clk_en,
    output logic [1:0]  mode
);

    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int DIV_W  = DIV_MAX + 1;
    localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [DIV_W-1:0]    div_cnt_q;
    logic [DIV_W-1:0]    div_mask_s;
    logic [4:0]          eff_sel_s;
    logic                div_tick_s;
    logic                start_acc_s;
    logic                done_s1_q, done_s2_q, done_s3_q;
    logic                done_rise_s;
    logic                upg_rst_q, upg_rst_d;
    logic                cpu_rst_q, cpu_rst_d;
    logic                clk_en_q, clk_en_d;
    logic [1:0]          mode_q, mode_d;
    logic                prog_active_q, prog_active_d;
    logic [BANK_W-1:0]   bank_sel_s;
    logic                unused_adr_s;

    debounce_sync #(.CYCLES(DEBOUNCE_CYCLES)) u_start_db (
        .clk_i    (fpga_clk),
        .rst_ni   (fpga_rst_n),
        .din_i    (start_pg),
        .accept_o (start_acc_s)
    );

    // Synchronise the programmer done level and keep one extra stage for edge detect
    always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            done_s1_q <= 1'b0;
            done_s2_q <= 1'b0;
            done_s3_q <= 1'b0;
        end else begin
            done_s1_q <= upg.upg_done_i;
            done_s2_q <= done_s1_q;
            done_s3_q <= done_s2_q;
        end
    end

    // Only a 0->1 transition counts; a level already high is not a completion
    assign done_rise_s = done_s2_q && !done_s3_q;

    // Free-running divider counter
    always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
        end
    end

    // Tick whenever the low eff_sel counter bits are all ones (sel 0: every cycle)
    assign eff_sel_s  = clamp_sel(div_sel, DIV_MAX);
    assign div_mask_s = (DIV_W'(1) << eff_sel_s) - DIV_W'(1);
    assign div_tick_s = ((div_cnt_q & div_mask_s) == div_mask_s);

    // FSM state register
    always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            state_q <= ST_HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; a done edge in PROG overrides any press
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HOLD: begin
                if (hold_q == HOLD_W'(RST_HOLD_CYCLES - 1)) state_d = ST_RUN;
                else                                       state_d = ST_HOLD;
            end
            ST_RUN: begin
                if (start_acc_s) begin
`ifdef BOOT_CTRL_STEP_EN
                    if (div_sel == STEP_SEL) state_d = ST_STEP;
                    else                     state_d = ST_PROG;
`else
                    state_d = ST_PROG;
`endif
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_PROG: begin
                if (done_rise_s) state_d = ST_HOLD;
                else             state_d = ST_PROG;
            end
`ifdef BOOT_CTRL_STEP_EN
            ST_STEP: begin
                if (div_sel != STEP_SEL) state_d = ST_RUN;
                else                     state_d = ST_STEP;
            end
`endif
            default: state_d = ST_HOLD;
        endcase
    end

    // Hold counter runs only while staying in HOLD, so every entry starts at zero
    always_comb begin
        if ((state_q == ST_HOLD) && (state_d == ST_HOLD)) hold_d = hold_q + HOLD_W'(1);
        else                                              hold_d = '0;
    end

    // Hold counter register
    always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    // FSM output decode from the current state
    always_comb begin
        upg_rst_d     = 1'b1;
        cpu_rst_d     = 1'b1;
        clk_en_d      = 1'b0;
        prog_active_d = 1'b0;
        mode_d        = state_q;
        case (state_q)
            ST_HOLD: begin
                upg_rst_d = 1'b1;
                cpu_rst_d = 1'b1;
            end
            ST_RUN: begin
                cpu_rst_d = 1'b0;
                clk_en_d  = div_tick_s;
            end
            ST_PROG: begin
                upg_rst_d     = 1'b0;
                prog_active_d = 1'b1;
            end
`ifdef BOOT_CTRL_STEP_EN
            ST_STEP: begin
                cpu_rst_d = 1'b0;
                clk_en_d  = start_acc_s;
            end
`endif
            default: begin
                upg_rst_d = 1'b1;
                cpu_rst_d = 1'b1;
            end
        endcase
    end

    // Output registers: outputs follow the state one cycle later
    always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            upg_rst_q     <= 1'b1;
            cpu_rst_q     <= 1'b1;
            clk_en_q      <= 1'b0;
            mode_q        <= 2'd0;
            prog_active_q <= 1'b0;
        end else begin
            upg_rst_q     <= upg_rst_d;
            cpu_rst_q     <= cpu_rst_d;
            clk_en_q      <= clk_en_d;
            mode_q        <= mode_d;
            prog_active_q <= prog_active_d;
        end
    end

    assign upg_rst    = upg_rst_q;
    assign cpu_rst    = cpu_rst_q;
    assign cpu_clk_en = clk_en_q;
    assign mode       = mode_q;

    // Bank number comes from the top address bits; the rest is the in-bank offset
    assign bank_sel_s   = upg.upg_adr_i[ADR_W-1 -: BANK_W];
    assign unused_adr_s = ^upg.upg_adr_i[ADR_W-BANK_W-1:0];

    // Gate the write strobe so it never reaches memory outside a programming session
    always_comb begin
        upg.bank_wen = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            upg.bank_wen[i] = upg.upg_wen_i && prog_active_q && (bank_sel_s == BANK_W'(i));
        end
    end

endmodule

// File: tb/tb_boot_ctrl.sv
// Directed bench for boot_ctrl with a short debounce window.
module tb_boot_ctrl;

    localparam int DEB = 50;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_pg;
    logic [4:0]  div_sel;
    logic        upg_rst;
    logic        cpu_rst;
    logic        cpu_clk_en;
    logic [1:0]  mode;

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    int          fail_cnt  = 0;
    int          n;
    logic [15:0] pat;

    boot_ctrl_if #(.ADR_W(15), .NUM_BANKS(2)) bus ();

    boot_ctrl #(
        .ADR_W           (15),
        .NUM_BANKS       (2),
        .DEBOUNCE_CYCLES (DEB),
        .RST_HOLD_CYCLES (16),
        .DIV_MAX         (24)
    ) dut (
        .fpga_clk   (clk),
        .fpga_rst_n (rst_n),
        .start_pg   (start_pg),
        .div_sel    (div_sel),
        .upg        (bus.slave),
        .upg_rst    (upg_rst),
        .cpu_rst    (cpu_rst),
        .cpu_clk_en (cpu_clk_en),
        .mode       (mode)
    );

    always #5 clk = ~clk;

    task automatic step(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic count_en(input int cycles, output int ones);
        ones = 0;
        repeat (cycles) begin
            step(1);
            if (cpu_clk_en) ones++;
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        start_pg       = 1'b0;
        div_sel        = 5'd0;
        bus.upg_wen_i  = 1'b0;
        bus.upg_adr_i  = 15'h0000;
        bus.upg_done_i = 1'b0;
        step(2);
        chk("rst_upg_rst", upg_rst, 1);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_clk_en", cpu_clk_en, 0);
        chk("rst_mode", mode, 0);
        chk("rst_bank_wen", bus.bank_wen, 0);

        // Reset release: cpu_rst held for 16 cycles, then RUN with enable every cycle
        rst_n = 1'b1;
        n = 0;
        repeat (16) begin
            step(1);
            if (cpu_rst && !cpu_clk_en && mode == 2'd0) n++;
        end
        chk("hold_16_cycles", n, 16);
        step(1);
        chk("run_cpu_rst", cpu_rst, 0);
        chk("run_mode", mode, 1);
        chk("run_clk_en", cpu_clk_en, 1);
        count_en(8, n);
        chk("div0_every_cycle", n, 8);

        // div_sel=3: one-cycle pulse every 8 cycles
        div_sel = 5'd3;
        n = 0;
        do begin
            step(1);
            n++;
        end while (!cpu_clk_en && n < 20);
        chk("div3_found", cpu_clk_en, 1);
        for (int i = 0; i < 16; i++) begin
            step(1);
            pat[i] = cpu_clk_en;
        end
        chk("div3_pattern", pat, 16'h8080);

        // div_sel=30 clamps to 2^24: no pulse in a short window
        div_sel = 5'd30;
        step(2);
        count_en(300, n);
        chk("div30_quiet", n, 0);

        // Programmer writes outside PROG are blocked
        bus.upg_wen_i = 1'b1;
        bus.upg_adr_i = 15'h4010;
        #1;
        chk("run_bank_hi", bus.bank_wen, 0);
        bus.upg_adr_i = 15'h0004;
        #1;
        chk("run_bank_lo", bus.bank_wen, 0);
        bus.upg_wen_i = 1'b0;

        // done level goes high before PROG so it must not count as completion
        bus.upg_done_i = 1'b1;

        // Glitchy button: 10-cycle bursts never reach the 50-cycle window
        step(1);
        repeat (5) begin
            start_pg = 1'b1;
            step(10);
            start_pg = 1'b0;
            step(10);
        end
        chk("glitch_mode", mode, 1);
        chk("glitch_upg_rst", upg_rst, 1);

        // Stable press: upg_rst falls exactly 53 cycles later
        start_pg = 1'b1;
        n = 0;
        repeat (52) begin
            step(1);
            if (upg_rst) n++;
        end
        chk("start_wait_52", n, 52);
        step(1);
        chk("start_upg_rst_fall", upg_rst, 0);
        chk("prog_mode", mode, 2);
        chk("prog_cpu_rst", cpu_rst, 1);
        chk("prog_clk_en", cpu_clk_en, 0);

        // Bank steering in PROG
        bus.upg_wen_i = 1'b1;
        bus.upg_adr_i = 15'h4010;
        #1;
        chk("prog_bank_dmem", bus.bank_wen, 2'b10);
        bus.upg_adr_i = 15'h0004;
        #1;
        chk("prog_bank_rom", bus.bank_wen, 2'b01);
        bus.upg_wen_i = 1'b0;
        #1;
        chk("prog_bank_idle", bus.bank_wen, 0);
        start_pg = 1'b0;

        // Another press during PROG is ignored; high done level is not completion
        step(5);
        start_pg = 1'b1;
        step(60);
        chk("prog_press_ignored", mode, 2);
        start_pg = 1'b0;
        step(5);
        chk("done_level_ignored", mode, 2);

        // Real done rise: HOLD entered 3 cycles later, visible on mode one cycle after
        bus.upg_done_i = 1'b0;
        step(5);
        bus.upg_done_i = 1'b1;
        step(3);
        chk("done_e3_mode", mode, 2);
        step(1);
        chk("done_hold_mode", mode, 0);
        chk("done_hold_upg_rst", upg_rst, 1);
        chk("done_hold_cpu_rst", cpu_rst, 1);
        n = 0;
        repeat (15) begin
            step(1);
            if (cpu_rst) n++;
        end
        chk("done_hold_15", n, 15);
        step(1);
        chk("done_cpu_rst_fall", cpu_rst, 0);
        chk("done_run_mode", mode, 1);

        // Second session, aborted by reset mid-PROG
        start_pg = 1'b1;
        n = 0;
        do begin
            step(1);
            n++;
        end while (mode != 2'd2 && n < 100);
        chk("prog2_enter", mode, 2);
        chk("prog2_latency", n, 53);
        start_pg      = 1'b0;
        bus.upg_wen_i = 1'b1;
        bus.upg_adr_i = 15'h0000;
        #1;
        chk("prog2_bank_rom", bus.bank_wen, 2'b01);
        rst_n = 1'b0;
        #1;
        chk("abort_upg_rst", upg_rst, 1);
        chk("abort_cpu_rst", cpu_rst, 1);
        chk("abort_clk_en", cpu_clk_en, 0);
        chk("abort_mode", mode, 0);
        chk("abort_bank_wen", bus.bank_wen, 0);
        bus.upg_wen_i = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(20);
        chk("abort_back_run", mode, 1);
        chk("abort_upg_rst_hi", upg_rst, 1);

`ifdef BOOT_CTRL_STEP_EN
        // Single-step: enter with div_sel=31, then each press gives one pulse
        div_sel  = 5'd31;
        start_pg = 1'b1;
        step(60);
        start_pg = 1'b0;
        step(5);
        chk("step_enter", mode, 3);
        n = 0;
        repeat (3) begin
            start_pg = 1'b1;
            repeat (60) begin
                step(1);
                if (cpu_clk_en) n++;
            end
            start_pg = 1'b0;
            repeat (5) begin
                step(1);
                if (cpu_clk_en) n++;
            end
        end
        chk("step_pulses", n, 3);
        div_sel = 5'd0;
        step(3);
        chk("step_exit", mode, 1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
